commit_trace_fifo: RTL and testbench
====================================

# commit_trace_fifo

Buffers retired-instruction records from the CPU debug commit port and hands them to the checking side of the bench at its own pace. It also keeps the cycle and retired-instruction counters used for CPI reporting and flags end-of-program when a configured halt PC retires. It sits directly downstream of the CPU `debug_*` commit outputs and upstream of the reference-model comparator.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `ADDR_WIDTH`, 32: PC width.
- `DATA_WIDTH`, 32: instruction word width.
- `HALT_PC`, 224: retiring this PC ends the run.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `commit_valid_i` in 1: CPU retired an instruction this cycle.
- `commit_pc_i` in ADDR_WIDTH: PC of the retired instruction.
- `commit_instr_i` in DATA_WIDTH: retired instruction word.
- `rd_ready_i` in 1: consumer accepts the head entry.
- `rd_valid_o` out 1: head entry valid.
- `rd_pc_o` out ADDR_WIDTH: head PC.
- `rd_instr_o` out DATA_WIDTH: head instruction.
- `rd_stamp_o` out 32: cycle-count stamp of the head entry. Present only with TRACE_STAMP_EN.
- `level_o` out $clog2(DEPTH)+1: entries held.
- `cycle_count_o` out 32: cycles since reset release.
- `instr_count_o` out 32: commits observed.
- `drop_count_o` out 16: commits lost to a full FIFO. Saturates at 0xFFFF.
- `overflow_o` out 1: sticky; at least one commit was dropped.
- `done_o` out 1: sticky; HALT_PC has retired.

## Operation
- Show-ahead FIFO with a circular buffer. Read and write pointers are $clog2(DEPTH) bits plus a wrap bit.
  - Empty: pointers are equal.
  - Full: indices are equal and the wrap bits differ.
- Pop: occurs when `rd_valid_o && rd_ready_i`.
- Push: occurs when `commit_valid_i && !done_o`, provided the FIFO is not full, or it is full and a pop happens in the same cycle.
  - Simultaneous push and pop when full: both happen and the level is unchanged.
  - Simultaneous push and pop when empty: the push is accepted. The pop is impossible because `rd_valid_o` is 0.
- Drop: a commit arrives while full with no pop.
  - The entry is discarded.
  - `drop_count_o` increments, saturating.
  - `overflow_o` sets.
  - `instr_count_o` still increments.
- `instr_count_o`: increments on every `commit_valid_i` while `!done_o`. Wraps modulo 2^32.
- `cycle_count_o`: increments every cycle while `rst` is high and `!done_o`. Wraps modulo 2^32.
- Halt: when a commit with `commit_pc_i == HALT_PC` arrives while `!done_o`:
  - It is pushed or dropped and counted like any other commit.
  - `done_o` sets on the next edge.
  - From then on, commits are ignored and both counters freeze.
  - Pops continue, so the consumer can drain the FIFO.
- Reset: `rst` low at any edge, including mid-drain, clears pointers, all counters and both sticky flags. Buffer contents are not cleared.
- `commit_pc_i` and `commit_instr_i` are don't-care when `commit_valid_i` is 0.

## Timing
- Output values during reset: `rd_valid_o`, `level_o`, `cycle_count_o`, `instr_count_o`, `drop_count_o`, `overflow_o` and `done_o` are all 0. `rd_pc_o`, `rd_instr_o` and `rd_stamp_o` are don't-care while `rd_valid_o` is 0.
- Push latency: a commit accepted at edge N is visible at the head (`rd_valid_o=1`) after edge N if the FIFO was empty.
- Head outputs are combinational reads of the buffer at the read pointer and change only after a pop or on the first push into an empty FIFO.
- `level_o`, counters and flags are registered and reflect the state after the latest edge.
- `cycle_count_o` reads 0 in the first cycle after `rst` rises and 1 one cycle later.

## Configuration
- `TRACE_STAMP_EN`:
  - Defined: each entry stores a 32-bit stamp, which is the value of `cycle_count_o` in the cycle the commit was presented. The port `rd_stamp_o` exists.
  - Undefined: no stamp storage and no `rd_stamp_o` port. All other behaviour is identical.

## Test plan
- Single commit, DEPTH=16: after reset, `commit_valid_i=1` with PC=0x0 and instr=0x00500093 for one cycle. The next cycle must show `rd_valid_o=1`, `rd_pc_o=0`, `rd_instr_o=0x00500093`, `level_o=1` and `instr_count_o=1`. With the macro, `rd_stamp_o` equals the cycle count presented.
- Fill without reads: 17 back-to-back commits with `rd_ready_i=0` give `level_o=16`, `drop_count_o=1`, `overflow_o=1` and `instr_count_o=17`. Draining then returns PCs 0x0..0x3C in order.
- Full with simultaneous push and pop: at `level_o=16`, commit and pop together. Result: `level_o` stays 16, `drop_count_o` is unchanged, and the new PC is in the tail.
- Halt: commits at PCs 0x0, 0x4 and 0xE0 (224), then 0xE4. Result: `done_o=1` the cycle after 0xE0, `instr_count_o=3`, `cycle_count_o` frozen, and the 0xE4 commit is not enqueued. The FIFO drains all three entries.
- Reset mid-run: at `level_o=5`, pull `rst` low for one edge. All outputs go to 0 and `rd_valid_o=0`. The next commit appears as the sole entry.
- Pointer wrap: 40 commits with `rd_ready_i=1` held high. Every entry must come out once, in order, with `level_o ≤ 1`, and no drops.

Source files
------------

// File: rtl/commit_trace_fifo_if.sv
// rtl/commit_trace_fifo_if.sv - commit-in / trace-out signal bundle for commit_trace_fifo
// rd_stamp_o exists only when TRACE_STAMP_EN is defined.
interface commit_trace_fifo_if #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  commit_valid_i;
  logic [ADDR_WIDTH-1:0] commit_pc_i;
  logic [DATA_WIDTH-1:0] commit_instr_i;
  logic                  rd_ready_i;
  logic                  rd_valid_o;
  logic [ADDR_WIDTH-1:0] rd_pc_o;
  logic [DATA_WIDTH-1:0] rd_instr_o;
`ifdef TRACE_STAMP_EN
  logic [31:0]           rd_stamp_o;
`endif
  logic [LW-1:0]         level_o;
  logic [31:0]           cycle_count_o;
  logic [31:0]           instr_count_o;
  logic [15:0]           drop_count_o;
  logic                  overflow_o;
  logic                  done_o;

  modport slave (
    input  commit_valid_i, commit_pc_i, commit_instr_i, rd_ready_i,
    output rd_valid_o, rd_pc_o, rd_instr_o,
`ifdef TRACE_STAMP_EN
    output rd_stamp_o,
`endif
    output level_o, cycle_count_o, instr_count_o, drop_count_o, overflow_o, done_o
  );

  modport master (
    output commit_valid_i, commit_pc_i, commit_instr_i, rd_ready_i,
    input  rd_valid_o, rd_pc_o, rd_instr_o,
`ifdef TRACE_STAMP_EN
    input  rd_stamp_o,
`endif
    input  level_o, cycle_count_o, instr_count_o, drop_count_o, overflow_o, done_o
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - show-ahead retired-instruction FIFO with CPI counters and halt detect
// Optional TRACE_STAMP_EN stores a 32-bit cycle stamp per entry and drives rd_stamp_o.
module commit_trace_fifo #(
  parameter int                    DEPTH      = 16,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] HALT_PC    = 224
) (
  input  logic               clk,
  input  logic               rst,
  commit_trace_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_WIDTH+ADDR_WIDTH-1:0] mem [DEPTH];
`ifdef TRACE_STAMP_EN
  logic [31:0] stamp_mem [DEPTH];
`endif

  logic [AW:0] wr_ptr, rd_ptr, level;
  logic [31:0] cycle_count, instr_count;
  logic [15:0] drop_count;
  logic        overflow, done;

  logic empty, full, pop, commit_ok, push, drop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop       = !empty && bus.rd_ready_i;
  assign commit_ok = bus.commit_valid_i && !done;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign push      = commit_ok && (!full || pop);
  assign drop      = commit_ok && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {bus.commit_instr_i, bus.commit_pc_i};
`ifdef TRACE_STAMP_EN
      stamp_mem[wr_ptr[AW-1:0]] <= cycle_count;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + PTR_ONE;
        2'b01:   level <= level - PTR_ONE;
        default: level <= level;
      endcase
      if (!done) cycle_count <= cycle_count + 32'd1;
      if (commit_ok) instr_count <= instr_count + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (commit_ok && bus.commit_pc_i == HALT_PC) done <= 1'b1;
    end
  end

  assign bus.rd_valid_o    = !empty;
  assign bus.rd_pc_o       = mem[rd_ptr[AW-1:0]][ADDR_WIDTH-1:0];
  assign bus.rd_instr_o    = mem[rd_ptr[AW-1:0]][DATA_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
`ifdef TRACE_STAMP_EN
  assign bus.rd_stamp_o    = stamp_mem[rd_ptr[AW-1:0]];
`endif
  assign bus.level_o       = level;
  assign bus.cycle_count_o = cycle_count;
  assign bus.instr_count_o = instr_count;
  assign bus.drop_count_o  = drop_count;
  assign bus.overflow_o    = overflow;
  assign bus.done_o        = done;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb/tb_commit_trace_fifo.sv - directed bench for commit_trace_fifo
// Stamp check compiled in only with TRACE_STAMP_EN.
module tb_commit_trace_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  commit_trace_fifo_if #(.DEPTH(16), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  commit_trace_fifo #(.DEPTH(16), .ADDR_WIDTH(32), .DATA_WIDTH(32), .HALT_PC(32'd224)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.commit_valid_i = 1'b0;
    bus.rd_ready_i     = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] instr);
    bus.commit_valid_i = 1'b1;
    bus.commit_pc_i    = pc;
    bus.commit_instr_i = instr;
    tick();
    bus.commit_valid_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"},    32'(bus.rd_valid_o),    32'd0);
    chk({tag, "_level"},    32'(bus.level_o),       32'd0);
    chk({tag, "_cycle"},    bus.cycle_count_o,      32'd0);
    chk({tag, "_instr"},    bus.instr_count_o,      32'd0);
    chk({tag, "_drop"},     32'(bus.drop_count_o),  32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow_o),    32'd0);
    chk({tag, "_done"},     32'(bus.done_o),        32'd0);
  endtask

  initial begin
    bus.commit_valid_i = 1'b0;
    bus.commit_pc_i    = '0;
    bus.commit_instr_i = '0;
    bus.rd_ready_i     = 1'b0;
    tick();
    tick();
    check_idle("reset");

    // single commit
    rst = 1'b1;
    chk("first_cycle", bus.cycle_count_o, 32'd0);
    commit(32'h0, 32'h00500093);
    chk("single_valid", 32'(bus.rd_valid_o), 32'd1);
    chk("single_pc",    bus.rd_pc_o,         32'h0);
    chk("single_instr", bus.rd_instr_o,      32'h00500093);
    chk("single_level", 32'(bus.level_o),    32'd1);
    chk("single_icnt",  bus.instr_count_o,   32'd1);
    chk("single_cycle", bus.cycle_count_o,   32'd1);
`ifdef TRACE_STAMP_EN
    chk("single_stamp", bus.rd_stamp_o,      32'd0);
`endif
    bus.rd_ready_i = 1'b1;
    tick();
    bus.rd_ready_i = 1'b0;
    chk("single_pop_valid", 32'(bus.rd_valid_o), 32'd0);

    // fill past full, then full push+pop
    do_reset();
    for (int i = 0; i < 17; i++) commit(32'(i * 4), 32'(i + 256));
    chk("fill_level",    32'(bus.level_o),      32'd16);
    chk("fill_drop",     32'(bus.drop_count_o), 32'd1);
    chk("fill_overflow", 32'(bus.overflow_o),   32'd1);
    chk("fill_icnt",     bus.instr_count_o,     32'd17);
    chk("fill_head",     bus.rd_pc_o,           32'h0);
    bus.rd_ready_i = 1'b1;
    commit(32'h100, 32'hABCD);
    chk("fullpp_level", 32'(bus.level_o),      32'd16);
    chk("fullpp_drop",  32'(bus.drop_count_o), 32'd1);
    chk("fullpp_head",  bus.rd_pc_o,           32'h4);
    for (int k = 0; k < 16; k++) begin
      chk("drain_valid", 32'(bus.rd_valid_o), 32'd1);
      chk("drain_pc", bus.rd_pc_o, (k < 15) ? 32'((k + 1) * 4) : 32'h100);
      tick();
    end
    bus.rd_ready_i = 1'b0;
    chk("drain_empty", 32'(bus.rd_valid_o), 32'd0);

    // halt
    do_reset();
    commit(32'h0, 32'h1);
    commit(32'h4, 32'h2);
    chk("halt_not_yet", 32'(bus.done_o), 32'd0);
    commit(32'hE0, 32'h3);
    chk("halt_done",  32'(bus.done_o),   32'd1);
    chk("halt_icnt",  bus.instr_count_o, 32'd3);
    chk("halt_cycle", bus.cycle_count_o, 32'd3);
    commit(32'hE4, 32'h4);
    tick();
    chk("halt_level",        32'(bus.level_o),   32'd3);
    chk("halt_icnt_frozen",  bus.instr_count_o,  32'd3);
    chk("halt_cycle_frozen", bus.cycle_count_o,  32'd3);
    bus.rd_ready_i = 1'b1;
    chk("halt_drain0", bus.rd_pc_o, 32'h0);
    tick();
    chk("halt_drain1", bus.rd_pc_o, 32'h4);
    tick();
    chk("halt_drain2", bus.rd_pc_o, 32'hE0);
    tick();
    bus.rd_ready_i = 1'b0;
    chk("halt_empty",     32'(bus.rd_valid_o), 32'd0);
    chk("halt_done_held", 32'(bus.done_o),     32'd1);

    // reset mid-run
    do_reset();
    for (int i = 0; i < 5; i++) commit(32'(i * 4 + 64), 32'(i));
    chk("mid_level", 32'(bus.level_o), 32'd5);
    rst = 1'b0;
    tick();
    check_idle("midrst");
    rst = 1'b1;
    commit(32'h200, 32'h55);
    chk("midrst_level", 32'(bus.level_o), 32'd1);
    chk("midrst_pc",    bus.rd_pc_o,      32'h200);
    bus.rd_ready_i = 1'b1;
    tick();
    chk("midrst_empty", 32'(bus.rd_valid_o), 32'd0);

    // pointer wrap with consumer always ready
    do_reset();
    bus.rd_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      commit(32'(i * 4), 32'(i ^ 32'h5A5A));
      chk("wrap_pc",    bus.rd_pc_o,         32'(i * 4));
      chk("wrap_instr", bus.rd_instr_o,      32'(i ^ 32'h5A5A));
      chk("wrap_level", 32'(bus.level_o),    32'd1);
    end
    tick();
    chk("wrap_empty", 32'(bus.rd_valid_o),   32'd0);
    chk("wrap_drop",  32'(bus.drop_count_o), 32'd0);
    chk("wrap_icnt",  bus.instr_count_o,     32'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
